// File: rtl/lcd_pixel_streamer.sv
// Raster-order pixel fetcher with a one-entry prefetch buffer, feeding a
// mode-0 SPI serializer that streams RGB565 pixels MSB-first to an LCD panel.
module lcd_pixel_streamer #(
    parameter int X_MAX      = 160,
    parameter int Y_MAX      = 80,
    parameter int CLK_DIV    = 2,
    parameter int CONTINUOUS = 0,
    localparam int XW = $clog2(X_MAX - 1) + 1,
    localparam int YW = $clog2(Y_MAX - 1) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          frame_done,
    output logic          update,
    output logic [XW-1:0] update_x,
    output logic [YW-1:0] update_y,
    input  logic          done,
    input  logic [15:0]   done_color,
    output logic          lcd_cs_n,
    output logic          lcd_dc,
    output logic          lcd_sclk,
    output logic          lcd_mosi
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(X_MAX - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(Y_MAX - 1);

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fstate_t;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_END} sstate_t;

    fstate_t       f_state_q, f_state_d;
    sstate_t       s_state_q, s_state_d;
    logic          busy_q, busy_d;
    logic          all_req_q, all_req_d;
    logic [XW-1:0] fx_q, fx_d, upd_x_q, upd_x_d;
    logic [YW-1:0] fy_q, fy_d, upd_y_q, upd_y_d;
    logic [15:0]   buf_q, buf_d, sreg_q, sreg_d;
    logic          buf_valid_q, buf_valid_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic          load;

    always_comb begin
        f_state_d   = f_state_q;
        s_state_d   = s_state_q;
        busy_d      = busy_q;
        all_req_d   = all_req_q;
        fx_d        = fx_q;
        fy_d        = fy_q;
        upd_x_d     = upd_x_q;
        upd_y_d     = upd_y_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        load        = 1'b0;

        if (!busy_q && start) begin
            busy_d    = 1'b1;
            fx_d      = '0;
            fy_d      = '0;
            all_req_d = 1'b0;
        end

        // Shift side runs first so a done arriving in the same cycle wins buf_valid.
        case (s_state_q)
            S_IDLE: load = buf_valid_q;
            S_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (sclk_q) begin
                        if (bit_cnt_q == 4'd0) begin
                            if (buf_valid_q)     load      = 1'b1;
                            else if (!all_req_q) s_state_d = S_IDLE;
                            else                 s_state_d = S_END;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 4'd1;
                            sreg_d    = {sreg_q[14:0], 1'b0};
                            mosi_d    = sreg_q[14];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CW'(1);
                end
            end
            S_END: begin
                cs_n_d    = 1'b1;
                s_state_d = S_IDLE;
                fx_d      = '0;
                fy_d      = '0;
                all_req_d = 1'b0;
                if (CONTINUOUS == 0) busy_d = 1'b0;
            end
            default: s_state_d = S_IDLE;
        endcase

        if (load) begin
            sreg_d      = buf_q;
            buf_valid_d = 1'b0;
            cs_n_d      = 1'b0;
            mosi_d      = buf_q[15];
            bit_cnt_d   = 4'd15;
            div_cnt_d   = '0;
            s_state_d   = S_SHIFT;
        end

        case (f_state_q)
            F_IDLE: begin
                if (busy_q && !buf_valid_q && !all_req_q) begin
                    f_state_d = F_REQ;
                    upd_x_d   = fx_q;
                    upd_y_d   = fy_q;
                end
            end
            F_REQ: f_state_d = F_WAIT;
            F_WAIT: begin
                if (done) begin
                    buf_d       = done_color;
                    buf_valid_d = 1'b1;
                    f_state_d   = F_IDLE;
                    if (fx_q == X_LAST) begin
                        fx_d = '0;
                        if (fy_q == Y_LAST) begin
                            fy_d      = '0;
                            all_req_d = 1'b1;
                        end else begin
                            fy_d = fy_q + YW'(1);
                        end
                    end else begin
                        fx_d = fx_q + XW'(1);
                    end
                end
            end
            default: f_state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_state_q   <= F_IDLE;
            s_state_q   <= S_IDLE;
            busy_q      <= 1'b0;
            all_req_q   <= 1'b0;
            fx_q        <= '0;
            fy_q        <= '0;
            upd_x_q     <= '0;
            upd_y_q     <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            f_state_q   <= f_state_d;
            s_state_q   <= s_state_d;
            busy_q      <= busy_d;
            all_req_q   <= all_req_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            upd_x_q     <= upd_x_d;
            upd_y_q     <= upd_y_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = (s_state_q == S_END);
    assign update     = (f_state_q == F_REQ);
    assign update_x   = upd_x_q;
    assign update_y   = upd_y_q;
    assign lcd_cs_n   = cs_n_q;
    assign lcd_dc     = 1'b1;
    assign lcd_sclk   = sclk_q;
    assign lcd_mosi   = mosi_q;

endmodule
